// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and operation encoding for the Gray counter family.
// Functions work on MAX_W bits; callers zero-extend narrower codes and truncate the result.
package gray_pkg;

    localparam int MAX_W = 16;

    typedef logic [MAX_W-1:0] code_t;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } op_e;

    function automatic code_t bin2gray_f(input code_t bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    // Zero-extended upper bits leave the low bits of the result unaffected.
    function automatic code_t gray2bin_f(input code_t gray);
        code_t bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational binary->Gray and Gray->binary converter pair of generic width.
module gray_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_val,
    input  logic [WIDTH-1:0] gray_val,
    output logic [WIDTH-1:0] bin_as_gray,
    output logic [WIDTH-1:0] gray_as_bin
);

    // Both directions evaluated through the shared package helpers
    always_comb begin
        bin_as_gray = WIDTH'(bin2gray_f(MAX_W'(bin_val)));
        gray_as_bin = WIDTH'(gray2bin_f(MAX_W'(gray_val)));
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered binary, Gray and rollover-pulse outputs.
// Preload accepts either a binary or a Gray-coded value.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray_f(MAX_W'(RESET_BIN)));
    localparam logic [WIDTH-1:0] TERM_UP    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TERM_DOWN  = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_bin_s;
    logic [WIDTH-1:0] next_gray_s;
    logic             next_wrap_s;
    logic [WIDTH-1:0] load_bin_s;
    logic [WIDTH-1:0] conv_bin_s;
    op_e              op_s;

    // Gray view is derived from the next binary state so both register together
    gray_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .bin_val     (next_bin_s),
        .gray_val    (load_val),
        .bin_as_gray (next_gray_s),
        .gray_as_bin (conv_bin_s)
    );

    // Operation select: load has priority over counting
    always_comb begin
        op_s = OP_HOLD;
        if (load) begin
            op_s = OP_LOAD;
        end else if (en) begin
            op_s = OP_COUNT;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Preload value in binary form
    always_comb begin
        load_bin_s = load_val;
        if (load_is_gray) begin
            load_bin_s = conv_bin_s;
        end else begin
            load_bin_s = load_val;
        end
    end

    // Next binary state and rollover detection
    always_comb begin
        next_bin_s  = bin_r;
        next_wrap_s = 1'b0;
        case (op_s)
            OP_LOAD: begin
                next_bin_s = load_bin_s;
            end
            OP_COUNT: begin
                if (up) begin
                    next_bin_s  = bin_r + WIDTH'(1'b1);
                    next_wrap_s = (bin_r == TERM_UP);
                end else begin
                    next_bin_s  = bin_r - WIDTH'(1'b1);
                    next_wrap_s = (bin_r == TERM_DOWN);
                end
            end
            OP_HOLD: begin
                next_bin_s = bin_r;
            end
            default: begin
                next_bin_s  = bin_r;
                next_wrap_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset overriding load and count
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= RESET_BIN;
            gray_r <= RESET_GRAY;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            wrap_r <= next_wrap_s;
        end
    end

    assign bin_out  = bin_r;
    assign gray_out = gray_r;
    assign wrap     = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench: three counter instances (4-bit, 2-bit, 8-bit) driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic        load_is_gray;
    logic [15:0] load_val;

    logic [3:0] bin4, gray4;
    logic       wrap4;
    logic [1:0] bin2, gray2;
    logic       wrap2;
    logic [7:0] bin8, gray8;
    logic       wrap8;

    gray_counter #(.WIDTH(4), .RESET_VAL(0)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
        .load_val(load_val[3:0]), .bin_out(bin4), .gray_out(gray4), .wrap(wrap4)
    );

    gray_counter #(.WIDTH(2), .RESET_VAL(3)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
        .load_val(load_val[1:0]), .bin_out(bin2), .gray_out(gray2), .wrap(wrap2)
    );

    gray_counter #(.WIDTH(8), .RESET_VAL(3)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
        .load_val(load_val[7:0]), .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wid[3] = '{4, 2, 8};
    int rv[3]  = '{0, 3, 3};
    int m_bin[3];
    int m_wrap[3];
    int wraps[3];
    logic [31:0] ob_bin[3];
    logic [31:0] ob_gray[3];
    logic [31:0] ob_wrap[3];
    logic [31:0] prev_gray[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Closed form: each binary bit is the XOR of all Gray bits at or above it
    function automatic int ref_bin(input int g);
        int b = 0;
        for (int k = 0; k < 16; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic cycle();
        logic counted;
        @(posedge clk);
        counted = !rst && !load && en;
        for (int i = 0; i < 3; i++) begin
            int modv;
            int nb;
            modv = 1 << wid[i];
            if (rst) begin
                m_bin[i]  = rv[i];
                m_wrap[i] = 0;
            end else if (load) begin
                nb        = int'(load_val) & (modv - 1);
                m_bin[i]  = load_is_gray ? ref_bin(nb) : nb;
                m_wrap[i] = 0;
            end else if (en) begin
                nb        = up ? m_bin[i] + 1 : m_bin[i] - 1;
                m_wrap[i] = (nb < 0 || nb >= modv) ? 1 : 0;
                m_bin[i]  = (nb + modv) % modv;
            end else begin
                m_wrap[i] = 0;
            end
        end
        #1;
        ob_bin  = '{32'(bin4),  32'(bin2),  32'(bin8)};
        ob_gray = '{32'(gray4), 32'(gray2), 32'(gray8)};
        ob_wrap = '{32'(wrap4), 32'(wrap2), 32'(wrap8)};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bin_w%0d", wid[i]),  ob_bin[i],  m_bin[i]);
            check($sformatf("gray_w%0d", wid[i]), ob_gray[i], ref_gray(m_bin[i]));
            check($sformatf("wrap_w%0d", wid[i]), ob_wrap[i], m_wrap[i]);
            if (counted) begin
                check($sformatf("hamming_w%0d", wid[i]), $countones(ob_gray[i] ^ prev_gray[i]), 1);
            end
            prev_gray[i] = ob_gray[i];
            wraps[i] += int'(ob_wrap[i]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_is_gray = 1'b0; load_val = 16'd0;
        for (int i = 0; i < 3; i++) begin
            m_bin[i] = 0; m_wrap[i] = 0; wraps[i] = 0; prev_gray[i] = 32'd0;
        end

        // Reset values
        cycle(); cycle();
        check("rst_bin4", bin4, 0);   check("rst_gray4", gray4, 0); check("rst_wrap4", wrap4, 0);
        check("rst_bin2", bin2, 3);   check("rst_gray2", gray2, 2);
        check("rst_bin8", bin8, 3);   check("rst_gray8", gray8, 2);

        // Up-count through a full 4-bit cycle
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) wraps[i] = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (k == 0)  check("up_first_gray4", gray4, 4'b0001);
            if (k == 14) check("up_last_gray4", gray4, 4'b1000);
        end
        check("up_end_gray4", gray4, 0);
        check("up_wraps4", wraps[0], 1);

        // Down-count rollover from a binary preload
        en = 1'b0; load = 1'b1; load_is_gray = 1'b0; load_val = 16'd1;
        cycle();
        check("dn_load_bin4", bin4, 1);
        load = 1'b0; en = 1'b1; up = 1'b0;
        cycle();
        check("dn_bin4_a", bin4, 0);  check("dn_gray4_a", gray4, 0);     check("dn_wrap4_a", wrap4, 0);
        cycle();
        check("dn_bin4_b", bin4, 15); check("dn_gray4_b", gray4, 4'b1000); check("dn_wrap4_b", wrap4, 1);
        en = 1'b0;
        cycle();
        check("dn_wrap4_c", wrap4, 0);

        // Gray preload then count
        load = 1'b1; load_is_gray = 1'b1; load_val = 16'hC;
        cycle();
        check("gl_bin4", bin4, 4'b1000); check("gl_gray4", gray4, 4'b1100); check("gl_wrap4", wrap4, 0);
        load = 1'b0; load_is_gray = 1'b0; en = 1'b1; up = 1'b1;
        cycle();
        check("gl_inc_bin4", bin4, 4'b1001); check("gl_inc_gray4", gray4, 4'b1101);

        // Priority: load over count, reset over everything
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 16'd7;
        cycle();
        check("pri_load_bin4", bin4, 4'b0111);
        rst = 1'b1;
        cycle();
        check("pri_rst_bin4", bin4, 0); check("pri_rst_bin2", bin2, 3); check("pri_rst_bin8", bin8, 3);
        rst = 1'b0;

        // Hold then alternate direction every cycle
        load = 1'b1; en = 1'b0; load_val = 16'd5;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_bin4", bin4, 5); check("hold_wrap4", wrap4, 0);
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            up = (k % 2 == 0);
            cycle();
            check("flip_bin4", bin4, up ? 6 : 5);
        end

        // Full 256-step up cycle: each width wraps 256 / 2**WIDTH times
        rst = 1'b1; en = 1'b0;
        cycle();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) wraps[i] = 0;
        for (int k = 0; k < 256; k++) cycle();
        for (int i = 0; i < 3; i++) check($sformatf("sweep_wraps_w%0d", wid[i]), wraps[i], 256 >> wid[i]);

        // Consecutive down-wraps on the 2-bit counter
        up = 1'b0; load = 1'b1; load_val = 16'd0;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 3; i++) wraps[i] = 0;
        for (int k = 0; k < 8; k++) cycle();
        check("dn_wraps_w2", wraps[1], 2);

        // Randomised mixed traffic
        for (int k = 0; k < 400; k++) begin
            rst          = ($urandom_range(0, 31) == 0);
            load         = ($urandom_range(0, 7) == 0);
            load_is_gray = $urandom_range(0, 1) == 1;
            en           = ($urandom_range(0, 3) != 0);
            up           = $urandom_range(0, 1) == 1;
            load_val     = 16'($urandom);
            cycle();
        end

        // Package helpers against the closed-form model
        for (int k = 0; k < 20; k++) begin
            int v;
            v = int'($urandom_range(0, 65535));
            check("pkg_gray2bin", 32'(gray_pkg::gray2bin_f(16'(v))), ref_bin(v));
            check("pkg_bin2gray", 32'(gray_pkg::bin2gray_f(16'(v))), ref_gray(v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
